io_fabric: RTL and testbench

IO_FABRIC -- requirements
Module: io_fabric

---
 rtl/io_fabric.sv | 194 +++++++++++++++++++
 tb/tb_io_fabric.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_fabric.sv
// -----------------------------------------------------------------------------
// io_fabric
//   Address decoder and IO glue for an 8-bit CPU with a 16-bit address bus.
//   Steers each access to ROM, RAM, the three control registers or one of
//   NUM_SLOTS peripheral slots. Slot reads may stall the CPU for a per-slot
//   number of wait states.
//
//   The control registers are:
//     0x0000  bank low byte
//     0x0001  bank high byte
//     0x0002  bit0 = ROM disable
//   The bank register selects which slot the IO page talks to.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   addr_i/we_i/data_i  CPU address, write strobe, write data
//   data_o, rdy_o       CPU read data, ready (0 = stall)
//   ram_cs_o/rom_cs_o   memory chip selects (combinational)
//   ram_data_i/rom_data_i  memory read data
//   slot_rd_o           one-hot slot read select (combinational)
//   slot_wr_o           one-hot slot write pulse (registered)
//   slot_addr_o/slot_wdata_o  registered address low byte / write data
//   slot_rdata_i        packed slot read data, slot k in [8k+7:8k]
//   slot_wait_i         packed static wait counts, slot k in [WAIT_W*k +: WAIT_W]
//   bank_o, rom_en_o    control register state
// -----------------------------------------------------------------------------
module io_fabric #(
    parameter int          NUM_SLOTS = 8,
    parameter int          WAIT_W    = 3,
    parameter logic [7:0]  IO_PAGE   = 8'hFE
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [15:0]                   addr_i,
    input  logic                          we_i,
    input  logic [7:0]                    data_i,
    output logic [7:0]                    data_o,
    output logic                          rdy_o,
    output logic                          ram_cs_o,
    output logic                          rom_cs_o,
    input  logic [7:0]                    ram_data_i,
    input  logic [7:0]                    rom_data_i,
    output logic [NUM_SLOTS-1:0]          slot_rd_o,
    output logic [NUM_SLOTS-1:0]          slot_wr_o,
    output logic [7:0]                    slot_addr_o,
    output logic [7:0]                    slot_wdata_o,
    input  logic [NUM_SLOTS*8-1:0]        slot_rdata_i,
    input  logic [NUM_SLOTS*WAIT_W-1:0]   slot_wait_i,
    output logic [15:0]                   bank_o,
    output logic                          rom_en_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    state_t                 r_state;
    logic [WAIT_W-1:0]      r_cnt;
    logic [15:0]            r_bank;
    logic                   r_rom_dis;
    logic [NUM_SLOTS-1:0]   r_slot_wr;
    logic [7:0]             r_slot_addr;
    logic [7:0]             r_slot_wdata;

    logic                   w_rom_page;
    logic                   w_io_page;
    logic                   w_hi_win;
    logic                   w_reg_win;
    logic                   w_low_ram;
    logic [NUM_SLOTS-1:0]   w_sel;
    logic                   w_slot_hit;
    logic [7:0]             w_slot_rdata;
    logic [WAIT_W-1:0]      w_slot_wait;
    logic [7:0]             w_reg_rdata;
    logic                   w_trigger;
    logic                   w_not_wait;

    // Decode in priority order; each window excludes all higher ones so the
    // selects are mutually exclusive by construction.
    assign w_rom_page = (addr_i[15:8] == 8'hFF);
    assign w_io_page  = !w_rom_page && (addr_i[15:8] == IO_PAGE);
    assign w_hi_win   = !w_rom_page && !w_io_page &&
                        (addr_i >= 16'hE000) && (addr_i <= 16'hFDFF);
    assign w_reg_win  = !w_rom_page && !w_io_page && !w_hi_win &&
                        (addr_i <= 16'h0002);
    assign w_low_ram  = !w_rom_page && !w_io_page && !w_hi_win && !w_reg_win;

    // A bank value outside the populated slots matches no slot, so the
    // access falls through to "unmapped" with no select asserted.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_sel[gi] = w_io_page && (r_bank == 16'(gi));
        end
    endgenerate

    assign w_slot_hit = |w_sel;

    always_comb begin
        w_slot_rdata = 8'h00;
        w_slot_wait  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (w_sel[k]) begin
                w_slot_rdata = w_slot_rdata | slot_rdata_i[k*8 +: 8];
                w_slot_wait  = w_slot_wait  | slot_wait_i[k*WAIT_W +: WAIT_W];
            end
        end
    end

    always_comb begin
        case (addr_i[1:0])
            2'd0:    w_reg_rdata = r_bank[7:0];
            2'd1:    w_reg_rdata = r_bank[15:8];
            default: w_reg_rdata = {7'b0, r_rom_dis};
        endcase
    end

    assign rom_cs_o  = w_rom_page || (w_hi_win && !r_rom_dis);
    assign ram_cs_o  = (w_hi_win && r_rom_dis) || w_low_ram;
    assign slot_rd_o = w_sel;

    always_comb begin
        if (rom_cs_o)        data_o = rom_data_i;
        else if (ram_cs_o)   data_o = ram_data_i;
        else if (w_reg_win)  data_o = w_reg_rdata;
        else if (w_slot_hit) data_o = w_slot_rdata;
        else                 data_o = 8'hFF;
    end

    // The first wait cycle is the IDLE cycle in which the slow read is seen,
    // so rdy_o must drop combinationally. Gating with rst_i keeps rdy_o high
    // for the whole reset even if the CPU still presents the slow address.
    assign w_trigger  = !rst_i && (r_state == ST_IDLE) && !we_i &&
                        w_slot_hit && (w_slot_wait != '0);
    assign w_not_wait = (r_state != ST_WAIT);
    assign rdy_o      = !(w_trigger || (r_state == ST_WAIT));

    // r_cnt holds the stall cycles still to come after the current one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        if (w_slot_wait == CNT_ONE) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= w_slot_wait - CNT_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_ONE) r_state <= ST_DONE;
                    else                  r_cnt   <= r_cnt - CNT_ONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Control registers and slot write port. Writes are ignored while the
    // CPU is stalled so the bank cannot move under an in-flight slot read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bank       <= 16'h0000;
            r_rom_dis    <= 1'b0;
            r_slot_wr    <= '0;
            r_slot_addr  <= 8'h00;
            r_slot_wdata <= 8'h00;
        end else begin
            r_slot_addr  <= addr_i[7:0];
            r_slot_wdata <= data_i;
            r_slot_wr    <= (we_i && w_not_wait) ? w_sel : '0;
            if (we_i && w_not_wait && w_reg_win) begin
                case (addr_i[1:0])
                    2'd0:    r_bank[7:0]  <= data_i;
                    2'd1:    r_bank[15:8] <= data_i;
                    default: r_rom_dis    <= data_i[0];
                endcase
            end
        end
    end

    assign slot_wr_o    = r_slot_wr;
    assign slot_addr_o  = r_slot_addr;
    assign slot_wdata_o = r_slot_wdata;
    assign bank_o       = r_bank;
    assign rom_en_o     = !r_rom_dis;

endmodule

// File: tb/tb_io_fabric.sv
// -----------------------------------------------------------------------------
// tb_io_fabric
//   Self-checking bench for io_fabric. The bench plays the CPU: it holds an
//   access until rdy_o is seen high, then moves on. A memory-map model built
//   from the address rules predicts selects, read data, stall length and the
//   slot write pulse of every access.
// -----------------------------------------------------------------------------
module tb_io_fabric;

    localparam int NS = 8;
    localparam int WW = 3;

    localparam int R_ROM  = 0;
    localparam int R_RAM  = 1;
    localparam int R_REG  = 2;
    localparam int R_SLOT = 3;
    localparam int R_NONE = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [15:0]       addr_i;
    logic              we_i;
    logic [7:0]        data_i;
    logic [7:0]        data_o;
    logic              rdy_o;
    logic              ram_cs_o;
    logic              rom_cs_o;
    logic [7:0]        ram_data_i;
    logic [7:0]        rom_data_i;
    logic [NS-1:0]     slot_rd_o;
    logic [NS-1:0]     slot_wr_o;
    logic [7:0]        slot_addr_o;
    logic [7:0]        slot_wdata_o;
    logic [NS*8-1:0]   slot_rdata_i;
    logic [NS*WW-1:0]  slot_wait_i;
    logic [15:0]       bank_o;
    logic              rom_en_o;

    io_fabric #(.NUM_SLOTS(NS), .WAIT_W(WW), .IO_PAGE(8'hFE)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .rdy_o        (rdy_o),
        .ram_cs_o     (ram_cs_o),
        .rom_cs_o     (rom_cs_o),
        .ram_data_i   (ram_data_i),
        .rom_data_i   (rom_data_i),
        .slot_rd_o    (slot_rd_o),
        .slot_wr_o    (slot_wr_o),
        .slot_addr_o  (slot_addr_o),
        .slot_wdata_o (slot_wdata_o),
        .slot_rdata_i (slot_rdata_i),
        .slot_wait_i  (slot_wait_i),
        .bank_o       (bank_o),
        .rom_en_o     (rom_en_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int n_txn = 0;

    // Reference state: what the control registers should hold.
    int   m_bank    = 0;
    bit   m_rom_dis = 1'b0;
    int   wait_tab [NS] = '{0, 1, 2, 3, 7, 0, 5, 7};

    // Expected slot write pulse in the first cycle of the next access.
    logic [NS-1:0] exp_wr_pend = '0;
    logic [7:0]    exp_saddr   = 8'h00;
    logic [7:0]    exp_swdata  = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d, t=%0t)", tag, got, exp, n_txn, $time);
        end
    endtask

    function automatic int region_of(input logic [15:0] a);
        int page;
        page = int'(a) / 256;
        if (page == 255) return R_ROM;
        if (page == 254) return (m_bank < NS) ? R_SLOT : R_NONE;
        if (int'(a) >= 'hE000 && int'(a) <= 'hFDFF) return m_rom_dis ? R_RAM : R_ROM;
        if (int'(a) <= 2) return R_REG;
        return R_RAM;
    endfunction

    function automatic logic [7:0] read_of(input logic [15:0] a, input int region);
        case (region)
            R_ROM:  return rom_data_i;
            R_RAM:  return ram_data_i;
            R_REG: begin
                if (a == 16'd0)      return 8'(m_bank % 256);
                else if (a == 16'd1) return 8'(m_bank / 256);
                else                 return {7'b0, m_rom_dis};
            end
            R_SLOT: return slot_rdata_i[m_bank*8 +: 8];
            default: return 8'hFF;
        endcase
    endfunction

    task automatic randomize_data();
        rom_data_i   = 8'($urandom);
        ram_data_i   = 8'($urandom);
        slot_rdata_i = {$urandom, $urandom};
    endtask

    // One CPU access; called 1ns after a rising edge, returns 1ns after the
    // edge that completes it.
    task automatic acc(input logic [15:0] a, input logic w, input logic [7:0] d);
        int            region;
        int            exp_stall;
        int            stalls;
        logic [7:0]    exp_d;
        logic [NS-1:0] exp_rd;
        addr_i = a;
        we_i   = w;
        data_i = d;
        region    = region_of(a);
        exp_d     = read_of(a, region);
        exp_rd    = (region == R_SLOT) ? NS'(1 << m_bank) : '0;
        exp_stall = (region == R_SLOT && !w) ? wait_tab[m_bank] : 0;
        stalls    = 0;

        @(negedge clk_i);
        check_val("slot_wr", slot_wr_o, exp_wr_pend);
        if (exp_wr_pend != '0) begin
            check_val("slot_addr", slot_addr_o, exp_saddr);
            check_val("slot_wdata", slot_wdata_o, exp_swdata);
        end
        for (int c = 0; c < 20; c++) begin
            check_val("rom_cs", rom_cs_o, region == R_ROM);
            check_val("ram_cs", ram_cs_o, region == R_RAM);
            check_val("slot_rd", slot_rd_o, exp_rd);
            check_val("bank", bank_o, 16'(m_bank));
            check_val("rom_en", rom_en_o, !m_rom_dis);
            if (rdy_o) break;
            stalls++;
            @(negedge clk_i);
            check_val("slot_wr_stall", slot_wr_o, 0);
        end
        check_val("stall_cycles", stalls, exp_stall);
        if (!w) check_val("rdata", data_o, exp_d);

        @(posedge clk_i);
        #1;
        exp_wr_pend = '0;
        if (w) begin
            if (region == R_REG) begin
                if (a == 16'd0)      m_bank = (m_bank / 256) * 256 + int'(d);
                else if (a == 16'd1) m_bank = (m_bank % 256) + int'(d) * 256;
                else                 m_rom_dis = d[0];
            end else if (region == R_SLOT) begin
                exp_wr_pend = NS'(1 << m_bank);
                exp_saddr   = a[7:0];
                exp_swdata  = d;
            end
        end
        $display("txn %0d addr=%h we=%b wdata=%h rdata=%h stalls=%0d bank=%h", n_txn, a, w, d, data_o, stalls, bank_o);
        n_txn++;
    endtask

    task automatic rand_txn();
        int         cat;
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        cat = int'($urandom_range(0, 9));
        w   = ($urandom_range(0, 2) == 0);
        d   = 8'($urandom);
        case (cat)
            0:       a = {8'hFF, 8'($urandom)};
            1, 2, 3: a = {8'hFE, 8'($urandom)};
            4:       a = 16'($urandom_range(32'hE000, 32'hFDFF));
            5, 6: begin
                a = 16'($urandom_range(0, 2));
                if (w && a == 16'd0) d = 8'($urandom_range(0, 9));
                if (w && a == 16'd1) d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            default: a = 16'($urandom);
        endcase
        randomize_data();
        acc(a, w, d);
    endtask

    initial begin
        for (int k = 0; k < NS; k++) slot_wait_i[k*WW +: WW] = WW'(wait_tab[k]);
        randomize_data();
        rst_i  = 1'b1;
        addr_i = 16'hFE05;
        we_i   = 1'b1;
        data_i = 8'h77;
        #3;
        check_val("rst_bank", bank_o, 16'h0000);
        check_val("rst_rom_en", rom_en_o, 1'b1);
        check_val("rst_rdy", rdy_o, 1'b1);
        check_val("rst_slot_wr", slot_wr_o, 0);
        @(posedge clk_i);
        #3;
        check_val("rst_slot_addr", slot_addr_o, 8'h00);
        check_val("rst_slot_wdata", slot_wdata_o, 8'h00);
        check_val("rst_slot_wr2", slot_wr_o, 0);
        addr_i = 16'h1000;
        we_i   = 1'b0;
        #3;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // ROM page read right after reset
        rom_data_i = 8'h5A;
        acc(16'hFFFC, 1'b0, 8'h00);
        // Bank 3 then slot write; following two accesses see the pulse then none
        acc(16'h0000, 1'b1, 8'h03);
        acc(16'hFE05, 1'b1, 8'h41);
        acc(16'h1234, 1'b0, 8'h00);
        acc(16'h1235, 1'b0, 8'h00);
        // Slow slot read, 3 wait states
        slot_rdata_i[3*8 +: 8] = 8'hC3;
        acc(16'hFE00, 1'b0, 8'h00);
        acc(16'h0002, 1'b0, 8'h00);
        // ROM disable: high window becomes RAM, top page stays ROM
        acc(16'h0002, 1'b1, 8'h01);
        acc(16'hE000, 1'b0, 8'h00);
        acc(16'hFF00, 1'b0, 8'h00);
        acc(16'h0002, 1'b0, 8'h00);
        acc(16'h0002, 1'b1, 8'h00);
        // Unpopulated bank
        acc(16'h0000, 1'b1, 8'h20);
        acc(16'hFE10, 1'b0, 8'h00);
        acc(16'hFE10, 1'b1, 8'h99);
        acc(16'h0000, 1'b0, 8'h00);
        // Longest wait count (7) on slot 4, single wait on slot 1
        acc(16'h0000, 1'b1, 8'h04);
        acc(16'hFE44, 1'b0, 8'h00);
        acc(16'h0000, 1'b1, 8'h01);
        acc(16'hFE01, 1'b0, 8'h00);

        // Reset in the second wait cycle of a slow read
        acc(16'h0000, 1'b1, 8'h03);
        addr_i = 16'hFE00;
        we_i   = 1'b0;
        @(negedge clk_i);
        check_val("abort_first_stall", rdy_o, 1'b0);
        @(posedge clk_i);
        #3;
        check_val("abort_still_stalled", rdy_o, 1'b0);
        rst_i = 1'b1;
        #1;
        check_val("abort_rdy", rdy_o, 1'b1);
        check_val("abort_bank", bank_o, 16'h0000);
        check_val("abort_rom_en", rom_en_o, 1'b1);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        m_bank      = 0;
        m_rom_dis   = 1'b0;
        exp_wr_pend = '0;
        @(negedge clk_i);
        check_val("abort_slot_wr", slot_wr_o, 0);
        @(posedge clk_i);
        #1;
        acc(16'h2000, 1'b0, 8'h00);

        for (int i = 0; i < 300; i++) rand_txn();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
